// File: rtl/bit_plotter_pkg.sv
// Shared definitions for the bit plotter / bit player pair. Default widths live here so the
// sample rate of the plotter and the play rate of the player stay matched.
package bit_plotter_pkg;

    localparam int unsigned BP_PRESCALE_WIDTH = 13;
    localparam int unsigned BP_ADDR_WIDTH     = 14;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPrefetch = 2'd1,
        StPlay     = 2'd2
    } bp_state_e;

endpackage

// File: rtl/bit_store.sv
// Simple dual-port 2^ADDR_WIDTH x 1 synchronous RAM, one write port and one read port.
// Read data is registered, giving a one-cycle read latency; written so it infers block RAM.
module bit_store #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rdata
);

    logic mem [2**ADDR_WIDTH];
    logic rdata_q;

    // Write and registered read; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bit_player.sv
// Serial pattern player: a host loads bits into bit_store while idle, then start replays them
// on bitOut, each bit held 2^PRESCALE_WIDTH cycles. start is registered once, so the first
// bit appears two edges after the edge that samples start.
// Build option: define BIT_PLAYER_LOOP_EN to wrap back to bit 0 forever instead of finishing
// with a done pulse.
module bit_player
    import bit_plotter_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = BP_PRESCALE_WIDTH,
    parameter int unsigned ADDR_WIDTH     = BP_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                loadEnable,
    input  logic                loadBit,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    output logic                bitOut,
    output logic                busy,
    output logic                done,
    output logic                full,
    output logic [ADDR_WIDTH:0] length
);

    // Counter value at which the last cycle of a bit begins, and the one before it, where the
    // next bit's read is issued so its data is ready exactly at the wrap.
    localparam logic [PRESCALE_WIDTH-1:0] PreLast  = {PRESCALE_WIDTH{1'b1}};
    localparam logic [PRESCALE_WIDTH-1:0] PreFetch = PreLast - PRESCALE_WIDTH'(1);

    bp_state_e                 state_q, state_d;
    logic                      start_q, start_d;
    logic [ADDR_WIDTH:0]       length_q, length_d;
    logic [ADDR_WIDTH-1:0]     read_idx_q, read_idx_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      bit_out_q, bit_out_d;
    logic                      done_q, done_d;

    logic                      ram_we;
    logic                      ram_re;
    logic [ADDR_WIDTH-1:0]     ram_raddr;
    logic                      ram_rdata;
    logic                      full_w;
    logic                      last_w;
    logic [ADDR_WIDTH-1:0]     next_idx_w;

    assign full_w     = length_q[ADDR_WIDTH];
    assign next_idx_w = read_idx_q + ADDR_WIDTH'(1);
    assign last_w     = (({1'b0, read_idx_q} + (ADDR_WIDTH + 1)'(1)) == length_q);

    bit_store #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_store (
        .clk  (clk),
        .we   (ram_we),
        .waddr(length_q[ADDR_WIDTH-1:0]),
        .wdata(loadBit),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

    // Next-state logic: clear beats stop beats start beats loadEnable.
    always_comb begin
        state_d    = state_q;
        start_d    = start & ~stop & ~clear;
        length_d   = length_q;
        read_idx_d = read_idx_q;
        presc_d    = presc_q;
        bit_out_d  = bit_out_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_raddr  = '0;

        if (clear) begin
            state_d   = StIdle;
            length_d  = '0;
            bit_out_d = 1'b0;
        end else if (stop && (state_q != StIdle)) begin
            state_d   = StIdle;
            bit_out_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_q && (length_q != '0)) begin
                        // Launch: fetch bit 0 now so it is waiting when PREFETCH ends.
                        state_d    = StPrefetch;
                        read_idx_d = '0;
                        ram_re     = 1'b1;
                    end else if (loadEnable && !start && !stop && !full_w) begin
                        ram_we   = 1'b1;
                        length_d = length_q + (ADDR_WIDTH + 1)'(1);
                    end
                end
                StPrefetch: begin
                    state_d   = StPlay;
                    bit_out_d = ram_rdata;
                    presc_d   = '0;
                end
                StPlay: begin
                    presc_d = presc_q + PRESCALE_WIDTH'(1);
                    if (presc_q == PreFetch) begin
                        ram_re    = 1'b1;
                        ram_raddr = last_w ? '0 : next_idx_w;
                    end
                    if (presc_q == PreLast) begin
                        if (!last_w) begin
                            read_idx_d = next_idx_w;
                            bit_out_d  = ram_rdata;
                        end else begin
`ifdef BIT_PLAYER_LOOP_EN
                            read_idx_d = '0;
                            bit_out_d  = ram_rdata;
`else
                            state_d    = StIdle;
                            bit_out_d  = 1'b0;
                            done_d     = 1'b1;
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            length_q   <= '0;
            read_idx_q <= '0;
            presc_q    <= '0;
            bit_out_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            length_q   <= length_d;
            read_idx_q <= read_idx_d;
            presc_q    <= presc_d;
            bit_out_q  <= bit_out_d;
            done_q     <= done_d;
        end
    end

    assign bitOut = bit_out_q;
    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign full   = full_w;
    assign length = length_q;

endmodule

// File: tb/tb_bit_player.sv
// Self-checking bench for bit_player with 4-cycle bits and a 16-entry buffer.
// Expected playback comes from the loaded pattern queue: output cycle k shows pattern[k/4].
module tb_bit_player;

    localparam int unsigned P  = 2;
    localparam int unsigned AW = 4;
    localparam int         Bp = 4;

    logic          clk;
    logic          resetN;
    logic          loadEnable;
    logic          loadBit;
    logic          start;
    logic          stop;
    logic          clear;
    logic          bitOut;
    logic          busy;
    logic          done;
    logic          full;
    logic [AW:0]   length;

    int n_checks;
    int n_pass;
    logic pat[$];

    bit_player #(
        .PRESCALE_WIDTH(P),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .loadEnable(loadEnable),
        .loadBit   (loadBit),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .bitOut    (bitOut),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .length    (length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        pat.delete();
    endtask

    task automatic load_pat();
        for (int i = 0; i < pat.size(); i++) begin
            loadEnable = 1'b1;
            loadBit    = pat[i];
            cyc();
        end
        loadEnable = 1'b0;
        loadBit    = 1'b0;
    endtask

    // Pulse start, then compare ncyc output cycles against pattern[(k/Bp) % size].
    task automatic play_run(input string name, input int ncyc, input bit noisy_load);
        logic [2:0] exp;
        int         len;
        len   = pat.size();
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_checks++;
        if ({bitOut, busy, done} !== 3'b000)
            $display("FAIL %s sample_edge got=%b exp=000", name, {bitOut, busy, done});
        else n_pass++;
        cyc();
        n_checks++;
        if ({bitOut, busy, done} !== 3'b010)
            $display("FAIL %s prefetch got=%b exp=010", name, {bitOut, busy, done});
        else n_pass++;
        for (int k = 0; k < ncyc; k++) begin
            if (noisy_load) begin
                loadEnable = 1'($urandom_range(0, 1));
                loadBit    = 1'($urandom_range(0, 1));
            end
            cyc();
            exp = {pat[(k / Bp) % len], 1'b1, 1'b0};
            n_checks++;
            if ({bitOut, busy, done} !== exp)
                $display("FAIL %s cycle=%0d got=%b exp=%b", name, k, {bitOut, busy, done}, exp);
            else n_pass++;
        end
        loadEnable = 1'b0;
        loadBit    = 1'b0;
    endtask

    // After the last bit: single pass ends with a done pulse; loop build is stopped by hand.
    task automatic finish_play(input string name);
`ifdef BIT_PLAYER_LOOP_EN
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++;
        if ({bitOut, busy, done} !== 3'b000)
            $display("FAIL %s loop_stop got=%b exp=000", name, {bitOut, busy, done});
        else n_pass++;
`else
        cyc();
        n_checks++;
        if ({bitOut, busy, done} !== 3'b001)
            $display("FAIL %s end_edge got=%b exp=001", name, {bitOut, busy, done});
        else n_pass++;
        cyc();
        n_checks++;
        if ({bitOut, busy, done} !== 3'b000)
            $display("FAIL %s after_end got=%b exp=000", name, {bitOut, busy, done});
        else n_pass++;
`endif
        n_checks++;
        if (length !== (AW + 1)'(pat.size()))
            $display("FAIL %s length_kept got=%0d exp=%0d", name, length, pat.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #3;
        n_checks++;
        if ({bitOut, busy, done, full, length} !== '0)
            $display("FAIL reset outputs got=%b exp=0", {bitOut, busy, done, full, length});
        else n_pass++;
        cyc();
        cyc();
        resetN = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        do_clear();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        load_pat();
        n_checks++;
        if (length !== 5'd4) $display("FAIL basic length got=%0d exp=4", length);
        else n_pass++;
        play_run("basic", 4 * Bp, 1'b0);
        finish_play("basic");
    endtask

    task automatic test_random_play();
        int len;
        for (int r = 0; r < 3; r++) begin
            do_clear();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) pat.push_back(1'($urandom_range(0, 1)));
            load_pat();
            play_run("random", len * Bp, 1'b0);
            finish_play("random");
        end
    endtask

    task automatic test_empty_start();
        do_clear();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if ({bitOut, busy, done} !== 3'b000)
                $display("FAIL empty_start got=%b exp=000", {bitOut, busy, done});
            else n_pass++;
        end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < 17; i++) begin
            loadEnable = 1'b1;
            loadBit    = 1'b1;
            cyc();
            if (i == 14) begin
                n_checks++;
                if ({full, length} !== {1'b0, 5'd15})
                    $display("FAIL full_15 got=%b/%0d exp=0/15", full, length);
                else n_pass++;
            end
        end
        loadEnable = 1'b0;
        n_checks++;
        if ({full, length} !== {1'b1, 5'd16})
            $display("FAIL full_17 got=%b/%0d exp=1/16", full, length);
        else n_pass++;
        for (int i = 0; i < 16; i++) pat.push_back(1'b1);
        play_run("full", 16 * Bp, 1'b0);
        finish_play("full");
    endtask

    task automatic test_stop();
        do_clear();
        pat = '{1'b1, 1'b0};
        load_pat();
        play_run("stop_pre", 1, 1'b0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++;
        if ({bitOut, busy, done} !== 3'b000)
            $display("FAIL stop_edge got=%b exp=000", {bitOut, busy, done});
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_checks++;
            if ({bitOut, busy, done, length} !== {3'b000, 5'd2})
                $display("FAIL stop_idle got=%b exp=00000010", {bitOut, busy, done, length});
            else n_pass++;
        end
        play_run("stop_replay", 2 * Bp, 1'b0);
        finish_play("stop_replay");
    endtask

    task automatic test_clear_reset();
        do_clear();
        pat = '{1'b1, 1'b0};
        load_pat();
        play_run("clear_pre", 3, 1'b0);
        clear = 1'b1;
        stop  = 1'b1;
        start = 1'b1;
        cyc();
        clear = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({bitOut, busy, done, full, length} !== '0)
            $display("FAIL clear got=%b exp=0", {bitOut, busy, done, full, length});
        else n_pass++;
        cyc();
        n_checks++;
        if ({bitOut, busy, done, full, length} !== '0)
            $display("FAIL clear_after got=%b exp=0", {bitOut, busy, done, full, length});
        else n_pass++;
        pat = '{1'b1, 1'b0};
        load_pat();
        play_run("reset_pre", 2, 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        n_checks++;
        if ({bitOut, busy, done, full, length} !== '0)
            $display("FAIL async_reset got=%b exp=0", {bitOut, busy, done, full, length});
        else n_pass++;
        cyc();
        resetN = 1'b1;
        cyc();
        pat.delete();
    endtask

    task automatic test_loop();
        do_clear();
        pat = '{1'b1, 1'b0, 1'b0};
        load_pat();
        play_run("loop", 4 * 3 * Bp, 1'b1);
        finish_play("loop");
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        loadEnable = 1'b0;
        loadBit    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        clear      = 1'b0;
        test_reset();
        test_empty_start();
        test_stop();
        test_clear_reset();
`ifdef BIT_PLAYER_LOOP_EN
        test_loop();
`else
        test_basic();
        test_random_play();
        test_full();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
